spi_shift_unit: RTL and testbench
=================================

SPI_SHIFT_UNIT -- requirements
Module: spi_shift_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 8: operand/result width; SHALL be a power of two, at least 4.
REQ-002 Parameter NSS_INDEX, default 0: bit of spi.nss that selects this slave.
REQ-003 Port i_clock, input, 1: system clock; all sampling and driving on its rising edge.
REQ-004 Port i_reset, input, 1: reset, asynchronous, active-low.
REQ-005 Port spi, Spi.SlaveSpi modport: nss (select, active-low), mosi (request bits), miso (response bits, tri-state).
REQ-006 Port o_busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-007 Local widths: SHAMT_W = clog2(DATA_WIDTH); REQ_W = 3 + DATA_WIDTH + SHAMT_W; RSP_W = DATA_WIDTH + 3.
REQ-008 Request packing, LSB first on mosi: bits [2:0] op_code, then operand, then shift amount.
REQ-009 Response packing, LSB first on miso: result, then carry, then zero, then error.
REQ-010 Op codes SHALL be: 0 SHL, 1 SHR (logical), 2 SAR (arithmetic), 3 ROL, 4 ROR; 5-7 invalid.
REQ-011 FSM states SHALL be IDLE, RECEIVE, COMPUTE, READY and SEND.
REQ-012 IDLE to RECEIVE when selected and mosi = 1 (start bit); the first request bit is sampled in the following cycle.
REQ-013 RECEIVE SHALL sample exactly REQ_W bits on consecutive cycles, then enter COMPUTE.
REQ-014 COMPUTE SHALL load the working register with the operand and then shift or rotate it one position per cycle.
- Occupancy is shift amount + 1 cycles; shift amount 0 gives 1 cycle, result = operand.
REQ-015 Carry SHALL be the last bit shifted or rotated out, and 0 when the shift amount is 0.
REQ-016 Zero SHALL be 1 when the final result is all zeros.
REQ-017 Invalid op: result 0, carry 0, zero 1, error 1; COMPUTE lasts 1 cycle.
REQ-018 COMPUTE SHALL then enter READY.
REQ-019 READY SHALL drive miso = 1 while selected, and enter SEND when selected and mosi = 1 (master acknowledge).
REQ-020 SEND SHALL drive RSP_W bits, one per cycle, starting the cycle after the acknowledge, then return to IDLE.
REQ-021 miso SHALL be high-Z when deselected, and 0 while selected in IDLE, RECEIVE or COMPUTE.
REQ-022 Deselect during RECEIVE or SEND SHALL abort: next state IDLE, bit counter cleared, partial packet discarded.
REQ-023 Deselect during COMPUTE or READY SHALL NOT abort; the result is held until a later acknowledge.
REQ-024 Bit counter SHALL wrap to 0 at the end of every RECEIVE and SEND phase.

Reset
REQ-025 On reset assertion, state SHALL be IDLE, o_busy 0, and all counters, packet registers and flags 0.
REQ-026 On reset assertion, miso SHALL be high-Z if deselected, else 0.
REQ-027 Reset SHALL take effect immediately in any state, including mid-RECEIVE, mid-COMPUTE and mid-SEND.
REQ-028 The first start bit SHALL be honoured on the first clock edge after reset deassertion.

Structure
REQ-029 Package Isa SHALL hold the ShiftOp enum and the op-code width constant.
REQ-030 Width-dependent packet sizes SHALL be local parameters in spi_shift_unit.
REQ-031 Sub-module shift_step SHALL perform the combinational single-position shift/rotate.
- Inputs: word, op. Outputs: next word, bit out.

Verification (DATA_WIDTH = 8)
REQ-032 SHL 0x81 by 1 -> result 0x02, carry 1, zero 0, error 0; COMPUTE lasts 2 cycles.
REQ-033 SAR 0x80 by 3 -> result 0xF0, carry 0; ROR 0x01 by 1 -> result 0x80, carry 1.
REQ-034 SHR 0x5A by 0 -> result 0x5A, carry 0, COMPUTE 1 cycle; op 7 -> result 0x00, zero 1, error 1.
REQ-035 Deselect after 5 request bits -> IDLE next cycle, o_busy 0, miso high-Z.
- A following full request SHALL complete correctly.
REQ-036 Deselect in READY, reselect 10 cycles later, then acknowledge -> response still correct.
REQ-037 Reset asserted mid-SEND -> IDLE, miso 0 while selected, all registers 0.

Source files
------------

// File: rtl/spi_shift_unit_pkg.sv
// Shift-unit instruction set: op-code encoding shared by the SPI front end and the datapath.
package Isa;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SHL = 3'd0,
        OP_SHR = 3'd1,
        OP_SAR = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } ShiftOp;

    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        return op <= 3'(OP_ROR);
    endfunction

endpackage

// File: rtl/spi_shift_unit_if.sv
// SPI bus bundle; the slave drives miso data plus an output enable that resolves the tri-state line.
interface Spi #(
    parameter int NSS_WIDTH = 1
);
    logic [NSS_WIDTH-1:0] nss;
    logic                 mosi;
    logic                 miso_d;
    logic                 miso_oe;
    wire                  miso;

    assign miso = miso_oe ? miso_d : 1'bz;

    modport SlaveSpi (
        input  nss,
        input  mosi,
        output miso_d,
        output miso_oe
    );

    modport MasterSpi (
        output nss,
        output mosi,
        input  miso,
        input  miso_oe
    );
endinterface

// File: rtl/spi_shift_unit_shift_step.sv
// Single-position shift/rotate; bit_out is the bit that leaves the word this step.
module shift_step
    import Isa::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] word,
    input  ShiftOp           op,
    output logic [WIDTH-1:0] next_word,
    output logic             bit_out
);
    always_comb begin
        next_word = word;
        bit_out   = 1'b0;
        case (op)
            OP_SHL: begin
                next_word = {word[WIDTH-2:0], 1'b0};
                bit_out   = word[WIDTH-1];
            end
            OP_SHR: begin
                next_word = {1'b0, word[WIDTH-1:1]};
                bit_out   = word[0];
            end
            OP_SAR: begin
                next_word = {word[WIDTH-1], word[WIDTH-1:1]};
                bit_out   = word[0];
            end
            OP_ROL: begin
                next_word = {word[WIDTH-2:0], word[WIDTH-1]};
                bit_out   = word[WIDTH-1];
            end
            OP_ROR: begin
                next_word = {word[0], word[WIDTH-1:1]};
                bit_out   = word[0];
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/spi_shift_unit.sv
// SPI slave that receives a shift request, iterates it one bit per cycle, and returns
// result/carry/zero/error after a master acknowledge.
module spi_shift_unit
    import Isa::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NSS_INDEX  = 0
) (
    input  logic i_clock,
    input  logic i_reset,
    Spi.SlaveSpi spi,
    output logic o_busy
);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);
    localparam int REQ_W   = OP_W + DATA_WIDTH + SHAMT_W;
    localparam int RSP_W   = DATA_WIDTH + 3;
    localparam int CNT_W   = $clog2(REQ_W);

    typedef enum logic [2:0] {
        IDLE,
        RECEIVE,
        COMPUTE,
        READY,
        SEND
    } state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic [REQ_W-1:0]        req_reg, req_next;
    logic [DATA_WIDTH-1:0]   work_reg, work_next;
    logic [RSP_W-1:0]        rsp_reg, rsp_next;
    logic                    miso_d;

    logic                    sel;
    logic [OP_W-1:0]         req_op;
    logic [DATA_WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0]      shamt;
    logic [DATA_WIDTH-1:0]   step_word;
    logic                    step_bit;
    logic [DATA_WIDTH-1:0]   result_val;
    logic                    carry_val;

    assign sel     = ~spi.nss[NSS_INDEX];
    assign req_op  = req_reg[OP_W-1:0];
    assign operand = req_reg[OP_W +: DATA_WIDTH];
    assign shamt   = req_reg[OP_W+DATA_WIDTH +: SHAMT_W];

    shift_step #(
        .WIDTH(DATA_WIDTH)
    ) u_step (
        .word      (work_reg),
        .op        (ShiftOp'(req_op)),
        .next_word (step_word),
        .bit_out   (step_bit)
    );

    // Step 0 only loads the operand, so a zero shift yields the operand with no carry.
    assign result_val = (cnt_reg == '0) ? operand : step_word;
    assign carry_val  = (cnt_reg == '0) ? 1'b0 : step_bit;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            req_reg   <= '0;
            work_reg  <= '0;
            rsp_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            req_reg   <= req_next;
            work_reg  <= work_next;
            rsp_reg   <= rsp_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        req_next   = req_reg;
        work_next  = work_reg;
        rsp_next   = rsp_reg;
        miso_d     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (sel && spi.mosi) begin
                    state_next = RECEIVE;
                    cnt_next   = '0;
                end
            end
            RECEIVE: begin
                if (!sel) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    req_next   = '0;
                end else begin
                    req_next = {spi.mosi, req_reg[REQ_W-1:1]};
                    if (cnt_reg == CNT_W'(REQ_W - 1)) begin
                        state_next = COMPUTE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                work_next = result_val;
                cnt_next  = cnt_reg + 1'b1;
                if (!op_is_valid(req_op)) begin
                    rsp_next   = {1'b1, 1'b1, 1'b0, {DATA_WIDTH{1'b0}}};
                    state_next = READY;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(shamt)) begin
                    rsp_next   = {1'b0, (result_val == '0), carry_val, result_val};
                    state_next = READY;
                    cnt_next   = '0;
                end
            end
            READY: begin
                miso_d = 1'b1;
                if (sel && spi.mosi) begin
                    state_next = SEND;
                    cnt_next   = '0;
                end
            end
            SEND: begin
                miso_d = rsp_reg[0];
                if (!sel) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    rsp_next   = '0;
                end else begin
                    rsp_next = rsp_reg >> 1;
                    if (cnt_reg == CNT_W'(RSP_W - 1)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign spi.miso_d  = miso_d;
    assign spi.miso_oe = sel;
    assign o_busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_spi_shift_unit.sv
// Directed bench for spi_shift_unit: requests go in over mosi, expected responses queue up
// in a scoreboard and are compared against what comes back on miso.
module tb_spi_shift_unit;
    import Isa::*;

    localparam int DW    = 8;
    localparam int RSP_W = DW + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   total = 0;
    int   bad = 0;
    logic [RSP_W-1:0] sb[$];

    always #5 clk = ~clk;

    Spi #(.NSS_WIDTH(2)) spi_bus ();

    spi_shift_unit #(
        .DATA_WIDTH(DW),
        .NSS_INDEX (1)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .spi    (spi_bus.SlaveSpi),
        .o_busy (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RSP_W-1:0] model(input logic [2:0] op, input logic [7:0] a,
                                                input logic [2:0] sh);
        logic [7:0]  r;
        logic        c;
        logic [15:0] t;
        int          s;
        s = int'(sh);
        c = 1'b0;
        r = 8'h00;
        case (op)
            3'd0: begin t = {8'h00, a} << s; r = t[7:0]; if (s > 0) c = t[8]; end
            3'd1: begin r = a >> s; if (s > 0) c = a[s-1]; end
            3'd2: begin r = $signed(a) >>> s; if (s > 0) c = a[s-1]; end
            3'd3: begin t = {a, a} << s; r = t[15:8]; if (s > 0) c = r[0]; end
            3'd4: begin t = {a, a} >> s; r = t[7:0]; if (s > 0) c = r[7]; end
            default: return {1'b1, 1'b1, 1'b0, 8'h00};
        endcase
        return {1'b0, (r == 8'h00), c, r};
    endfunction

    // Start bit plus 14 request bits; leaves the DUT in COMPUTE.
    task automatic send_req(input logic [2:0] op, input logic [7:0] a, input logic [2:0] sh);
        logic [13:0] req;
        req = {sh, a, op};
        spi_bus.nss[1] = 1'b0;
        spi_bus.mosi   = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            spi_bus.mosi = req[i];
            tick();
        end
        spi_bus.mosi = 1'b0;
        sb.push_back(model(op, a, sh));
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (spi_bus.miso !== 1'b1 && n < 40);
        check({tag, "_compute_cycles"}, n, exp_cycles);
    endtask

    task automatic get_rsp(input string tag);
        logic [RSP_W-1:0] got;
        logic [RSP_W-1:0] exp;
        spi_bus.mosi = 1'b1;
        tick();
        spi_bus.mosi = 1'b0;
        for (int i = 0; i < RSP_W; i++) begin
            got[i] = spi_bus.miso;
            tick();
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        check({tag, "_rsp"}, 32'(got), 32'(exp));
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        $display("txn %s rsp=%03h exp=%03h", tag, got, exp);
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [2:0] sh);
        send_req(op, a, sh);
        wait_ready(tag, (op <= 3'd4) ? int'(sh) + 1 : 1);
        get_rsp(tag);
    endtask

    initial begin
        spi_bus.nss  = 2'b11;
        spi_bus.mosi = 1'b0;
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_desel_oe", 32'(spi_bus.miso_oe), 32'd0);
        spi_bus.nss[1] = 1'b0;
        #1;
        check("reset_sel_miso", 32'(spi_bus.miso), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Start bit on the very first edge after reset release.
        run_op("shl81_1", 3'd0, 8'h81, 3'd1);
        run_op("sar80_3", 3'd2, 8'h80, 3'd3);
        run_op("ror01_1", 3'd4, 8'h01, 3'd1);
        run_op("shr5a_0", 3'd1, 8'h5A, 3'd0);
        run_op("op7", 3'd7, 8'hC3, 3'd2);
        run_op("rol96_5", 3'd3, 8'h96, 3'd5);
        run_op("shlff_7", 3'd0, 8'hFF, 3'd7);
        run_op("shr01_1", 3'd1, 8'h01, 3'd1);

        // Abort after 5 request bits.
        spi_bus.mosi = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            spi_bus.mosi = i[0];
            tick();
        end
        spi_bus.nss[1] = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_oe", 32'(spi_bus.miso_oe), 32'd0);
        $display("txn abort busy=%0b oe=%0b", busy, spi_bus.miso_oe);
        run_op("post_abort", 3'd2, 8'h7E, 3'd2);

        // Deselect while READY; result must survive.
        send_req(3'd3, 8'hA5, 3'd4);
        wait_ready("desel_ready", 5);
        spi_bus.nss[1] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("desel_ready_busy", 32'(busy), 32'd1);
        check("desel_ready_oe", 32'(spi_bus.miso_oe), 32'd0);
        spi_bus.nss[1] = 1'b0;
        #1;
        check("reselect_miso", 32'(spi_bus.miso), 32'd1);
        get_rsp("desel_ready");

        // Reset in the middle of SEND.
        send_req(3'd0, 8'hFF, 3'd1);
        wait_ready("rst_send", 2);
        spi_bus.mosi = 1'b1;
        tick();
        spi_bus.mosi = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        void'(sb.pop_front());
        check("rst_send_busy", 32'(busy), 32'd0);
        check("rst_send_miso", 32'(spi_bus.miso), 32'd0);
        check("rst_send_cnt", 32'(dut.cnt_reg), 32'd0);
        check("rst_send_req", 32'(dut.req_reg), 32'd0);
        check("rst_send_rsp", 32'(dut.rsp_reg), 32'd0);
        check("rst_send_work", 32'(dut.work_reg), 32'd0);
        $display("txn reset_mid_send busy=%0b miso=%0b", busy, spi_bus.miso);
        tick();
        rst_n = 1'b1;
        run_op("post_reset", 3'd4, 8'h3C, 3'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
